// File: rtl/err_compute_sm.sv
// err_compute_sm: sequencer for the IR line-error accumulator datapath.
// Each IR_vld pulse starts a sequence with these cycles:
//   1. One CLR cycle clears the accumulator.
//   2. NUM_TERMS ACCUM cycles step the operand mux through the weighted IR
//      terms. Each left term is subtracted and each right term is added.
//   3. One DONE cycle pulses err_vld while the datapath error is valid.
// An IR_vld that arrives during CLR or ACCUM is held as a single pending
// request. That request restarts the sequence directly from DONE.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   ir_vld_i     1-cycle pulse: new IR readings are stable
//   clr_accum_o  clear datapath accumulator (CLR only)
//   en_accum_o   accumulate selected operand (ACCUM only)
//   sub_o        subtract selected operand (ACCUM only)
//   sel_o        operand mux select (ACCUM only, else 0)
//   busy_o       sequence in progress (CLR, ACCUM, DONE)
//   err_vld_o    1-cycle pulse: datapath error holds the completed result
module err_compute_sm #(
  parameter int unsigned NUM_TERMS = 8,
  parameter bit          LEFT_SUB  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_vld_i,
  output logic       clr_accum_o,
  output logic       en_accum_o,
  output logic       sub_o,
  output logic [2:0] sel_o,
  output logic       busy_o,
  output logic       err_vld_o
);

  typedef enum logic [1:0] {StIdle, StClr, StAccum, StDone} state_e;

  localparam logic [2:0] LastCnt = 3'(NUM_TERMS - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Outputs are Moore-decoded from state/cnt only; ir_vld_i only steers next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    clr_accum_o = 1'b0;
    en_accum_o  = 1'b0;
    sub_o       = 1'b0;
    sel_o       = 3'd0;
    busy_o      = 1'b0;
    err_vld_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ir_vld_i) state_d = StClr;
      end
      StClr: begin
        clr_accum_o = 1'b1;
        busy_o      = 1'b1;
        cnt_d       = 3'd0;
        if (ir_vld_i) pending_d = 1'b1;
        state_d = StAccum;
      end
      StAccum: begin
        en_accum_o = 1'b1;
        busy_o     = 1'b1;
        sel_o      = cnt_q;
        // Even selects are right sensors and odd selects are left sensors.
        sub_o      = LEFT_SUB ? cnt_q[0] : ~cnt_q[0];
        if (ir_vld_i) pending_d = 1'b1;
        // Hold cnt on the last term; only CLR reloads it to zero.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        err_vld_o = 1'b1;
        busy_o    = 1'b1;
        if (pending_q || ir_vld_i) begin
          state_d   = StClr;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
